// File: rtl/gauss_conv_engine.sv
// gauss_conv_engine: applies a captured kernel to one pixel window, normalising by the weight sum.
// Define GAUSS_CONV_ROUND_EN for round-half-up normalisation (default truncates).
module gauss_conv_engine #(
    parameter int MAX_KERNEL = 7,
    parameter int PIX_W      = 8
) (
    input  logic                                          clk,
    input  logic                                          n_rst,
    input  logic                                          start,
    input  logic [$clog2(MAX_KERNEL)-1:0]                 kernel_size,
    input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]       kernel,
    input  logic [31:0]                                   sum,
    input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIX_W-1:0] window,
    output logic                                          busy,
    output logic                                          done,
    output logic [PIX_W-1:0]                              pixel_out,
    output logic                                          err
);
    localparam int KW = $clog2(MAX_KERNEL);
    typedef enum logic [1:0] {IDLE, MAC, DIV, OUT} state_t;
    state_t state;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] kern_r;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIX_W-1:0] win_r;
    logic [31:0] sum_r, acc, quo, acc_nxt;
    logic [KW-1:0] n_r, x, y;
    logic [4:0] cnt;
    logic [32:0] rem, rem_sh, dvd;
    logic [8+PIX_W-1:0] prod;
    logic [PIX_W-1:0] sat;
    logic err_f, x_last, last_tap, n_bad, fits;
    assign prod     = kern_r[x][y] * win_r[x][y];
    assign acc_nxt  = acc + 32'(prod);
    assign x_last   = x == n_r - KW'(1);
    assign last_tap = x_last && y == n_r - KW'(1);
    assign n_bad    = kernel_size == '0 || 32'(kernel_size) > MAX_KERNEL;
`ifdef GAUSS_CONV_ROUND_EN
    assign dvd = {1'b0, acc_nxt} + {2'b0, sum_r[31:1]};
`else
    assign dvd = {1'b0, acc_nxt};
`endif
    // Bit 32 of the dividend seeds the remainder so 32 iterations cover a 33-bit dividend.
    assign rem_sh = {rem[31:0], quo[31]};
    assign fits   = rem_sh >= {1'b0, sum_r};
    assign sat    = |quo[31:PIX_W] ? '1 : quo[PIX_W-1:0];
    assign busy   = state != IDLE || done;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            kern_r    <= '0;
            win_r     <= '0;
            sum_r     <= '0;
            n_r       <= '0;
            x         <= '0;
            y         <= '0;
            cnt       <= '0;
            acc       <= '0;
            quo       <= '0;
            rem       <= '0;
            err_f     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pixel_out <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    kern_r <= kernel;
                    win_r  <= window;
                    sum_r  <= sum;
                    n_r    <= kernel_size;
                    acc    <= '0;
                    x      <= '0;
                    y      <= '0;
                    cnt    <= '0;
                    err_f  <= n_bad;
                    state  <= n_bad ? OUT : MAC;
                end
                MAC: begin
                    acc <= acc_nxt;
                    x   <= x_last ? '0 : x + KW'(1);
                    y   <= x_last ? y + KW'(1) : y;
                    if (last_tap) begin
                        quo   <= dvd[31:0];
                        rem   <= {32'b0, dvd[32]};
                        err_f <= sum_r == '0;
                        state <= sum_r == '0 ? OUT : DIV;
                    end
                end
                DIV: begin
                    rem   <= fits ? rem_sh - {1'b0, sum_r} : rem_sh;
                    quo   <= {quo[30:0], fits};
                    cnt   <= cnt + 5'd1;
                    state <= cnt == 5'd31 ? OUT : DIV;
                end
                OUT: begin
                    done      <= 1'b1;
                    err       <= err_f;
                    pixel_out <= err_f ? '0 : sat;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gauss_conv_engine.sv
// tb_gauss_conv_engine: random and directed checks of gauss_conv_engine against an arithmetic model.
module tb_gauss_conv_engine;
    logic clk = 1'b0, n_rst = 1'b0, start = 1'b0;
    logic [2:0] kernel_size = '0;
    logic [6:0][6:0][7:0] kern = '0, win = '0;
    logic [31:0] sum = '0;
    logic busy, done, err;
    logic [7:0] pixel_out, prev_pix = '0;
    int errors = 0, checks = 0, done_cnt = 0;
    gauss_conv_engine dut (
        .clk(clk), .n_rst(n_rst), .start(start), .kernel_size(kernel_size),
        .kernel(kern), .sum(sum), .window(win),
        .busy(busy), .done(done), .pixel_out(pixel_out), .err(err)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt++;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // Expected result straight from the arithmetic definition of the filter.
    task automatic model(input int n, input logic [31:0] s, output logic [7:0] p, output logic e, output int lat);
        longint acc = 0, dvd, q;
        if (n == 0 || n > 7) begin
            p = 0; e = 1; lat = 1;
            return;
        end
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                acc += longint'(kern[i][j]) * longint'(win[i][j]);
        if (s == 0) begin
            p = 0; e = 1; lat = n * n + 1;
            return;
        end
        dvd = acc;
`ifdef GAUSS_CONV_ROUND_EN
        dvd += longint'(s) / 2;
`endif
        q = dvd / longint'(s);
        p = q > 255 ? 8'd255 : 8'(q);
        e = 0;
        lat = n * n + 33;
    endtask
    task automatic fill(input int kv, input int wv);
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++) begin
                kern[i][j] = 8'(kv);
                win[i][j]  = 8'(wv);
            end
    endtask
    task automatic scramble();
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++) begin
                kern[i][j] = 8'($urandom);
                win[i][j]  = 8'($urandom);
            end
        sum = $urandom;
        kernel_size = 3'($urandom);
    endtask
    task automatic run_op(input int n, input logic [31:0] s, input int poke);
        logic [7:0] ep;
        logic ee, busy_ok;
        int lat, cyc, d0;
        model(n, s, ep, ee, lat);
        @(negedge clk);
        kernel_size = 3'(n);
        sum = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_accept", busy, 1);
        check("done_accept", done, 0);
        check("pixel_hold", pixel_out, prev_pix);
        scramble();
        d0 = done_cnt;
        cyc = 0;
        busy_ok = 1;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            start = poke != 0 && cyc == poke;
            if (!busy) busy_ok = 0;
        end
        start = 1'b0;
        check("latency", cyc, lat);
        check("busy_through", busy_ok, 1);
        check("pixel", pixel_out, ep);
        check("err", err, ee);
        prev_pix = ep;
        if (poke != 0) begin
            repeat (60) @(posedge clk);
            #1;
            check("single_done", done_cnt - d0, 1);
        end
    endtask
    initial begin
        logic [31:0] s;
        int n;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_pixel", pixel_out, 0);
        n_rst = 1'b1;
        fill(1, 90);
        run_op(3, 9, 0);
        fill(0, 200);
        kern[2][2] = 100;
        win[2][2] = 37;
        run_op(5, 100, 0);
        fill(0, 0);
        kern[0][0] = 3;
        win[0][0] = 5;
        run_op(1, 2, 0);
        fill(255, 255);
        run_op(7, 49, 0);
        fill(1, 50);
        run_op(3, 0, 0);
        run_op(0, 9, 0);
        fill(2, 100);
        run_op(5, 50, 5);
        // Reset during the divide phase, then a fresh operation.
        fill(1, 90);
        @(negedge clk);
        kernel_size = 3'd3;
        sum = 9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("mid_div_busy", busy, 1);
        #2 n_rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_pixel", pixel_out, 0);
        @(negedge clk);
        n_rst = 1'b1;
        prev_pix = 0;
        fill(4, 77);
        run_op(4, 64, 0);
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(0, 7);
            for (int i = 0; i < 7; i++)
                for (int j = 0; j < 7; j++) begin
                    kern[i][j] = 8'($urandom);
                    win[i][j]  = 8'($urandom);
                end
            s = 0;
            if ($urandom_range(0, 9) == 0) s = 0;
            else if ($urandom_range(0, 1) == 0) s = 32'($urandom_range(1, 5000));
            else begin
                for (int i = 0; i < n; i++)
                    for (int j = 0; j < n; j++)
                        s += 32'(kern[i][j]);
            end
            run_op(n, s, 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
